unified_mem_arbiter: RTL and testbench
======================================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default simple_processor_pkg::ADDR_WIDTH (32), address bus width.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default simple_processor_pkg::DATA_WIDTH (32), data bus width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait cycles for mem_ack_i before an error completion.
REQ-004 SHALL have ports:
- clk_i  in  1  global synchronous clock, rising edge
- arst_ni  in  1  asynchronous active-low reset
- imem_req_i  in  1  instruction fetch request
- imem_addr_i  in  MEM_ADDR_WIDTH  fetch address
- imem_rdata_o  out  MEM_DATA_WIDTH  fetch read data
- imem_ack_o  out  1  fetch completion pulse
- dmem_req_i  in  1  data request
- dmem_we_i  in  1  data write enable
- dmem_addr_i  in  MEM_ADDR_WIDTH  data address
- dmem_wdata_i  in  MEM_DATA_WIDTH  data write data
- dmem_rdata_o  out  MEM_DATA_WIDTH  data read data
- dmem_ack_o  out  1  data completion pulse
- mem_req_o  out  1  unified memory request
- mem_we_o  out  1  unified memory write enable
- mem_addr_o  out  MEM_ADDR_WIDTH  unified memory address
- mem_wdata_o  out  MEM_DATA_WIDTH  unified memory write data
- mem_rdata_i  in  MEM_DATA_WIDTH  unified memory read data
- mem_ack_i  in  1  unified memory completion
- err_o  out  1  timeout-error pulse, coincident with the ack it qualifies

Function
REQ-005 SHALL implement FSM states IDLE, GRANT_I, GRANT_D; all outputs registered.
REQ-006 IDLE, only imem_req_i eligible -> GRANT_I; only dmem_req_i eligible -> GRANT_D; none -> stay IDLE.
REQ-007 Both eligible: SHALL grant the port not served last (round-robin); last_grant register resets to D, so I wins first.
REQ-008 A requester SHALL be ineligible in the cycle its own ack_o is high (prevents re-grant of a held request).
REQ-009 On the grant edge, SHALL latch the winner's addr, we and wdata to mem_addr_o/mem_we_o/mem_wdata_o; SHALL drive mem_we_o=0 for I grants; SHALL set mem_req_o=1.
REQ-010 Latched mem_* outputs SHALL stay stable while in GRANT_*, regardless of requester inputs or requester req deassertion.
REQ-011 In GRANT_x with mem_ack_i=1: next cycle x_ack_o=1 for exactly one cycle, x_rdata_o=mem_rdata_i (sampled at ack), mem_req_o=0, state IDLE, last_grant=x.
REQ-012 Latency: req sampled in IDLE at edge N -> mem_req_o high after edge N; mem_ack_i at edge M -> ack_o high after edge M; next mem_req_o earliest after edge M+1.
REQ-013 x_rdata_o SHALL hold its value until the next completion on the same port; writes SHALL also update rdata with mem_rdata_i.
REQ-014 A wait counter SHALL clear on grant and increment each GRANT_* cycle without mem_ack_i; reaching TIMEOUT_CYCLES SHALL complete as in REQ-011 with rdata=0 and err_o=1.
REQ-015 mem_ack_i in IDLE SHALL be ignored; mem_ack_i in the same cycle as timeout SHALL take precedence (normal completion, err_o=0).
REQ-016 imem_ack_o and dmem_ack_o SHALL never be high in the same cycle; at most one outstanding memory transaction.

Reset
REQ-017 On arst_ni low, asynchronously: state IDLE, last_grant=D, counter 0, all outputs 0, including mid-transaction; in-flight transaction abandoned, no ack issued.
REQ-018 After arst_ni deasserts, first grant SHALL occur no earlier than the first rising edge with arst_ni high.

Verification
REQ-019 Single read: imem_req_i=1, addr 0x100; mem_ack_i 2 cycles after mem_req_o with rdata 0xDEADBEEF -> mem_addr_o=0x100, mem_we_o=0, imem_ack_o one-cycle pulse, imem_rdata_o=0xDEADBEEF.
REQ-020 Contention: both req held continuously after reset, mem acks each after 1 cycle -> grant order I,D,I,D; no back-to-back same-port grant.
REQ-021 Data write: dmem_we_i=1, addr 0x40, wdata 0x1234 -> mem_we_o=1, mem_wdata_o=0x1234 stable until ack; dmem_ack_o single pulse.
REQ-022 Timeout: grant D, mem_ack_i never asserted -> after 16 wait cycles dmem_ack_o=1, err_o=1, dmem_rdata_o=0, state IDLE.
REQ-023 Reset mid-transaction: arst_ni low while in GRANT_I -> all outputs 0 immediately; no imem_ack_o after release; next grant goes to I.
REQ-024 Stray ack: mem_ack_i pulsed in IDLE -> no ack_o, no err_o, state unchanged.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter onto a single memory bus
// with one outstanding transaction, registered outputs and an ack-wait timeout.
module unified_mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      imem_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] imem_addr_i,
  output logic [MEM_DATA_WIDTH-1:0] imem_rdata_o,
  output logic                      imem_ack_o,
  input  logic                      dmem_req_i,
  input  logic                      dmem_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                      dmem_ack_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                      mem_ack_i,
  output logic                      err_o
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state_reg;
  logic             last_grant_d_reg;
  logic [CNT_W-1:0] wait_cnt_reg;

  logic i_elig, d_elig, pick_i, timeout;

  // A port whose ack is showing this cycle still has its old request up; skip it.
  assign i_elig  = imem_req_i & ~imem_ack_o;
  assign d_elig  = dmem_req_i & ~dmem_ack_o;
  assign pick_i  = i_elig & (~d_elig | last_grant_d_reg);
  assign timeout = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_reg        <= IDLE;
      last_grant_d_reg <= 1'b1;
      wait_cnt_reg     <= '0;
      imem_rdata_o     <= '0;
      imem_ack_o       <= 1'b0;
      dmem_rdata_o     <= '0;
      dmem_ack_o       <= 1'b0;
      mem_req_o        <= 1'b0;
      mem_we_o         <= 1'b0;
      mem_addr_o       <= '0;
      mem_wdata_o      <= '0;
      err_o            <= 1'b0;
    end else begin
      imem_ack_o <= 1'b0;
      dmem_ack_o <= 1'b0;
      err_o      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_elig || d_elig) begin
            state_reg    <= pick_i ? GRANT_I : GRANT_D;
            mem_req_o    <= 1'b1;
            mem_addr_o   <= pick_i ? imem_addr_i : dmem_addr_i;
            mem_we_o     <= ~pick_i & dmem_we_i;
            mem_wdata_o  <= pick_i ? '0 : dmem_wdata_i;
            wait_cnt_reg <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          // A real ack wins over a timeout landing in the same cycle.
          if (mem_ack_i || timeout) begin
            state_reg        <= IDLE;
            mem_req_o        <= 1'b0;
            err_o            <= ~mem_ack_i;
            last_grant_d_reg <= (state_reg == GRANT_D);
            if (state_reg == GRANT_I) begin
              imem_ack_o   <= 1'b1;
              imem_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            end else begin
              dmem_ack_o   <= 1'b1;
              dmem_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and random checks of unified_mem_arbiter against a transaction-level
// model of its arbitration, completion and timeout rules.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          imem_req_i = 1'b0;
  logic [AW-1:0] imem_addr_i = '0;
  logic [DW-1:0] imem_rdata_o;
  logic          imem_ack_o;
  logic          dmem_req_i = 1'b0;
  logic          dmem_we_i = 1'b0;
  logic [AW-1:0] dmem_addr_i = '0;
  logic [DW-1:0] dmem_wdata_i = '0;
  logic [DW-1:0] dmem_rdata_o;
  logic          dmem_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  unified_mem_arbiter #(
    .MEM_ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .arst_ni(arst_ni),
    .imem_req_i(imem_req_i),
    .imem_addr_i(imem_addr_i),
    .imem_rdata_o(imem_rdata_o),
    .imem_ack_o(imem_ack_o),
    .dmem_req_i(dmem_req_i),
    .dmem_we_i(dmem_we_i),
    .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_rdata_o(dmem_rdata_o),
    .dmem_ack_o(dmem_ack_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner 0 = nobody, 1 = instruction port, 2 = data port.
  int            m_owner, m_last, m_wait;
  logic          m_req, m_we, m_iack, m_dack, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_irdata, m_drdata;
  int            ack_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_wait = 0;
    m_req = 1'b0; m_we = 1'b0; m_iack = 1'b0; m_dack = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".mem_req"},    64'(mem_req_o),    64'(m_req));
    chk({ph, ".mem_we"},     64'(mem_we_o),     64'(m_we));
    chk({ph, ".mem_addr"},   64'(mem_addr_o),   64'(m_addr));
    chk({ph, ".mem_wdata"},  64'(mem_wdata_o),  64'(m_wdata));
    chk({ph, ".imem_ack"},   64'(imem_ack_o),   64'(m_iack));
    chk({ph, ".dmem_ack"},   64'(dmem_ack_o),   64'(m_dack));
    chk({ph, ".imem_rdata"}, 64'(imem_rdata_o), 64'(m_irdata));
    chk({ph, ".dmem_rdata"}, 64'(dmem_rdata_o), 64'(m_drdata));
    chk({ph, ".err"},        64'(err_o),        64'(m_err));
    chk({ph, ".ack_excl"},   64'(imem_ack_o & dmem_ack_o), 64'(0));
  endtask

  // Advance one clock: predict from the inputs in force, then compare after the edge.
  task automatic step(input string ph);
    int win;
    bit ie, de, done;
    logic [DW-1:0] rd;
    ie = imem_req_i && !m_iack;
    de = dmem_req_i && !m_dack;
    m_iack = 1'b0; m_dack = 1'b0; m_err = 1'b0;
    done = 1'b0; rd = '0; win = 0;
    if (m_owner == 0) begin
      if (ie && de)  win = (m_last == 2) ? 1 : 2;
      else if (ie)   win = 1;
      else if (de)   win = 2;
      if (win != 0) begin
        m_owner = win; m_req = 1'b1; m_wait = 0;
        if (win == 1) begin
          m_addr = imem_addr_i; m_we = 1'b0; m_wdata = '0;
        end else begin
          m_addr = dmem_addr_i; m_we = dmem_we_i; m_wdata = dmem_wdata_i;
        end
      end
    end else begin
      if (mem_ack_i) begin
        done = 1'b1; rd = mem_rdata_i;
      end else if (m_wait + 1 == TO) begin
        done = 1'b1; rd = '0; m_err = 1'b1;
      end else begin
        m_wait++;
      end
      if (done) begin
        if (m_owner == 1) begin m_iack = 1'b1; m_irdata = rd; end
        else              begin m_dack = 1'b1; m_drdata = rd; end
        m_req = 1'b0; m_last = m_owner; m_owner = 0;
      end
    end
    @(posedge clk_i); #1;
    check_all(ph);
  endtask

  // Entered 1 time unit after an edge; reset is pulled away from any clock edge.
  task automatic async_reset(input string ph);
    #2 arst_ni = 1'b0;
    #1 model_reset();
    check_all(ph);
    @(posedge clk_i); #1;
    check_all({ph, ".held"});
    arst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk_i); #1;
    check_all("reset");
    arst_ni = 1'b1;

    // Single instruction read, ack two cycles after the request
    imem_req_i = 1'b1; imem_addr_i = 32'h100;
    step("r019.grant");
    chk("r019.addr", 64'(mem_addr_o), 64'h100);
    imem_req_i = 1'b0;
    step("r019.wait");
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    step("r019.ack");
    chk("r019.ack_pulse", 64'(imem_ack_o), 64'd1);
    chk("r019.rdata", 64'(imem_rdata_o), 64'hDEADBEEF);
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    step("r019.after");
    chk("r019.ack_drop", 64'(imem_ack_o), 64'd0);

    // Contention straight after reset: strict alternation starting with I
    async_reset("r020.rst");
    imem_req_i = 1'b1; imem_addr_i = 32'h200;
    dmem_req_i = 1'b1; dmem_addr_i = 32'h300; dmem_we_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ack_i = m_req; mem_rdata_i = $urandom;
      step("r020.run");
      if (imem_ack_o) ack_q.push_back(1);
      if (dmem_ack_o) ack_q.push_back(2);
    end
    chk("r020.count", 64'(ack_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < ack_q.size(); i++)
      chk($sformatf("r020.order%0d", i), 64'(ack_q[i]), 64'((i % 2 == 0) ? 1 : 2));
    imem_req_i = 1'b0; dmem_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = m_req;
      step("r020.drain");
    end
    mem_ack_i = 1'b0;

    // Data write with requester inputs scrambled while granted
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h40; dmem_wdata_i = 32'h1234;
    step("r021.grant");
    dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = $urandom; dmem_wdata_i = $urandom;
    for (int i = 0; i < 2; i++) begin
      step("r021.hold");
      chk("r021.we", 64'(mem_we_o), 64'd1);
      chk("r021.wdata", 64'(mem_wdata_o), 64'h1234);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_0001;
    step("r021.ack");
    chk("r021.ack_pulse", 64'(dmem_ack_o), 64'd1);
    mem_ack_i = 1'b0;
    step("r021.after");
    chk("r021.ack_drop", 64'(dmem_ack_o), 64'd0);

    // Timeout on a data read
    dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 32'h80;
    step("r022.grant");
    dmem_req_i = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      step("r022.wait");
      chk($sformatf("r022.ack%0d", i), 64'(dmem_ack_o), 64'(i == TO));
    end
    chk("r022.err", 64'(err_o), 64'd1);
    chk("r022.rdata", 64'(dmem_rdata_o), 64'd0);
    chk("r022.req_low", 64'(mem_req_o), 64'd0);
    step("r022.after");

    // Stray ack while idle
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    step("r024.stray");
    chk("r024.err", 64'(err_o), 64'd0);
    mem_ack_i = 1'b0;
    step("r024.after");

    // Reset while an instruction fetch is outstanding; both ports then request
    imem_req_i = 1'b1; imem_addr_i = 32'h500;
    step("r023.grant");
    dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h600; dmem_wdata_i = 32'h77;
    async_reset("r023.rst");
    step("r023.regrant");
    chk("r023.first_is_i", 64'(mem_addr_o), 64'h500);
    chk("r023.no_ack", 64'(imem_ack_o), 64'd0);
    imem_req_i = 1'b0; dmem_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = m_req;
      step("r023.drain");
    end

    // Random traffic; later portion slows the memory so timeouts occur
    for (int it = 0; it < 600; it++) begin
      imem_req_i   = ($urandom_range(0, 2) != 0);
      imem_addr_i  = $urandom;
      dmem_req_i   = ($urandom_range(0, 2) != 0);
      dmem_we_i    = $urandom_range(0, 1) == 1;
      dmem_addr_i  = $urandom;
      dmem_wdata_i = $urandom;
      mem_rdata_i  = $urandom;
      if (m_req) mem_ack_i = (it >= 350) ? ($urandom_range(0, 19) == 0)
                                         : ($urandom_range(0, 2) == 0);
      else       mem_ack_i = ($urandom_range(0, 5) == 0);
      step("rand");
      if (it == 300) async_reset("rand.rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
